// File: rtl/div_seq_pkg.sv
// Shared project types for the divide sequencer: FSM states, handshake constants
// and the operand magnitude helper.
package project_types;

    localparam logic RST_ENABLE           = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam logic [5:0] DIV_ITERS = 6'd32;

    typedef enum logic [1:0] {
        DIV_FREE,
        DIV_BYZERO,
        DIV_ON,
        DIV_END
    } div_state_t;

    // Two's-complement magnitude, applied only for signed divides.
    function automatic logic [31:0] abs32(input logic [31:0] value, input logic is_signed);
        return (is_signed && value[31]) ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/div_seq.sv
// Multi-cycle 32-bit restoring divider for the EX stage; stalls the pipeline
// until {remainder, quotient} is ready.
module div_seq
    import project_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    div_state_t  state, state_next;
    logic [5:0]  cnt;
    logic [64:0] work;
    logic [31:0] divisor;
    logic        neg_quotient, neg_remainder;
    logic [63:0] result;

    logic [32:0] trial;
    logic [31:0] quotient_fix, remainder_fix;

    assign ready_o  = (state == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
    assign result_o = result;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_next    = state;
        trial         = work[64:32] - {1'b0, divisor};
        quotient_fix  = neg_quotient  ? (~work[31:0]  + 32'd1) : work[31:0];
        remainder_fix = neg_remainder ? (~work[64:33] + 32'd1) : work[64:33];
        stallreq_o    = start_i & ~ready_o & ~annul_i;

        case (state)
            DIV_FREE: begin
                if (start_i == DIV_START && !annul_i)
                    state_next = (opdata2_i == 32'd0) ? DIV_BYZERO : DIV_ON;
            end
            DIV_BYZERO: state_next = DIV_END;
            DIV_ON: begin
                if (cnt == DIV_ITERS)
                    state_next = DIV_END;
            end
            DIV_END: begin
                if (start_i == DIV_STOP)
                    state_next = DIV_FREE;
            end
            default: state_next = DIV_FREE;
        endcase

        if (annul_i)
            state_next = DIV_FREE;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state         <= DIV_FREE;
            cnt           <= '0;
            work          <= '0;
            divisor       <= '0;
            neg_quotient  <= 1'b0;
            neg_remainder <= 1'b0;
            result        <= '0;
        end else begin
            state <= state_next;
            if (annul_i) begin
                cnt    <= '0;
                result <= '0;
            end else begin
                case (state)
                    DIV_FREE: begin
                        if (start_i == DIV_START && opdata2_i != 32'd0) begin
                            divisor       <= abs32(opdata2_i, signed_div_i);
                            work          <= {32'b0, abs32(opdata1_i, signed_div_i), 1'b0};
                            neg_quotient  <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                            neg_remainder <= signed_div_i & opdata1_i[31];
                            cnt           <= '0;
                        end
                    end
                    DIV_BYZERO: result <= '0;
                    DIV_ON: begin
                        if (cnt != DIV_ITERS) begin
                            // A negative trial means the divisor did not fit: restore by plain shift.
                            work <= trial[32] ? {work[63:0], 1'b0}
                                              : {trial[31:0], work[31:0], 1'b1};
                            cnt  <= cnt + 6'd1;
                        end else begin
                            result <= {remainder_fix, quotient_fix};
                            cnt    <= '0;
                        end
                    end
                    DIV_END: begin
                        if (start_i == DIV_STOP)
                            result <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: latency, stall, signed fix-up,
// divide-by-zero, annul, async reset and result hold.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1, opdata2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready, stallreq;

    int checks = 0;
    int errors = 0;

    div_seq dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div),
        .opdata1_i   (opdata1),
        .opdata2_i   (opdata2),
        .start_i     (start),
        .annul_i     (annul),
        .result_o    (result),
        .ready_o     (ready),
        .stallreq_o  (stallreq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; drives a divide, holds start, returns at the negedge after ready.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] expected, input int exp_edges);
        int edges;
        int stalls;
        signed_div = sgn;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        #1 check($sformatf("%s stall_at_start", tag), 64'(stallreq), 64'd1);
        @(posedge clk);
        edges  = 0;
        stalls = 0;
        @(negedge clk);
        while (!ready && edges < 100) begin
            if (stallreq) stalls++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check($sformatf("%s latency", tag), 64'(edges), 64'(exp_edges));
        check($sformatf("%s stall_cycles", tag), 64'(stalls), 64'(exp_edges));
        check($sformatf("%s stall_low_at_ready", tag), 64'(stallreq), 64'd0);
        check($sformatf("%s result", tag), result, expected);
    endtask

    // Called at a negedge; drops start and confirms the return to FREE with a cleared result.
    task automatic finish_div(input string tag);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("%s ready_cleared", tag), 64'(ready), 64'd0);
        check($sformatf("%s result_cleared", tag), result, 64'd0);
    endtask

    initial begin
        logic        seen_ready;
        logic [63:0] held;

        rst        = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        start      = 1'b0;
        annul      = 1'b0;

        #12;
        check("reset ready", 64'(ready), 64'd0);
        check("reset result", result, 64'd0);
        check("reset stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        finish_div("divu_100_7");
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        finish_div("div_m7_2");
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
        finish_div("div_7_m2");
        run_div("divu_big_2", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC}, 33);
        finish_div("divu_big_2");
        run_div("div_by_zero", 1'b1, 32'd1234, 32'd0, 64'd0, 1);
        finish_div("div_by_zero");
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
        finish_div("div_min_m1");
        run_div("divu_5_9", 1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 33);
        finish_div("divu_5_9");
        run_div("divu_msb_divisor", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, {32'h7FFF_FFFF, 32'd1}, 33);
        finish_div("divu_msb_divisor");

        // Annul ten cycles into ON.
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd3;
        start      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        #1 check("annul stall_low", 64'(stallreq), 64'd0);
        @(posedge clk);
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        check("annul ready", 64'(ready), 64'd0);
        check("annul result", result, 64'd0);
        seen_ready = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (ready) seen_ready = 1'b1;
        end
        check("annul ready_never", 64'(seen_ready), 64'd0);
        run_div("after_annul", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33);
        finish_div("after_annul");

        // Async reset between edges while cnt == 17.
        signed_div = 1'b0;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        start      = 1'b1;
        @(posedge clk);
        repeat (17) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_on ready", 64'(ready), 64'd0);
        check("rst_on result", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rst_on stall_free", 64'(stallreq), 64'd0);
        run_div("after_reset", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33);

        // Async reset while a result is held in END.
        #2 rst = 1'b0;
        #1;
        check("rst_end ready", 64'(ready), 64'd0);
        check("rst_end result", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Hold start past ready, drop it, then re-raise the next cycle.
        run_div("hold", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        held = result;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            check("hold ready", 64'(ready), 64'd1);
            check("hold result", result, {32'd2, 32'd14});
        end
        check("hold result_unchanged", result, held);
        finish_div("hold");
        run_div("reraise", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33);
        finish_div("reraise");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
